// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default constants for the round-robin hold arbiter
//
// Purpose : FSM state type and default sizing constants used by rr_hold_arbiter.
// Contents: arb_state_t (IDLE/BUSY), ARB_NUM_REQ, ARB_MAX_HOLD.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_MAX_HOLD = 8;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick
//
// Purpose : find the first set bit of req, searching upward from ptr and
//           wrapping modulo N.
// Ports   : req   [N-1:0]  candidate request vector
//           ptr   [IW-1:0] index with highest priority (must be < N)
//           found          at least one bit of req is set
//           index [IW-1:0] winning index (0 when nothing found)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    always_comb begin
        int k;
        found = 1'b0;
        index = '0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k[IW-1:0]]) begin
                found = 1'b1;
                index = k[IW-1:0];
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter whose winner holds the grant until release
//
// Purpose : shares one multi-cycle resource between NUM_REQ requesters. The
//           owner keeps the grant until it asserts done or drops its request;
//           ownership then moves to the next pending requester in rotating
//           order on the same edge (no idle bubble).
// Macro   : ARB_TIMEOUT_EN - when defined, an owner that has held the grant
//           for MAX_HOLD cycles while someone else waits is force-released
//           and timeout pulses for one cycle. Undefined: timeout is 0.
// Ports   : clock              system clock
//           reset              asynchronous active-high reset
//           req   [NUM_REQ-1:0] level-sensitive requests
//           done               owner finished (ignored while idle)
//           grant [NUM_REQ-1:0] registered one-hot grant
//           grant_valid        registered OR of grant
//           grant_id           index of current owner, 0 when idle
//           timeout            one-cycle pulse on a forced release
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_id,
    output logic               timeout
);

    if (NUM_REQ < 2 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_hold_arbiter: NUM_REQ must be >= 2 and MAX_HOLD >= 1");
    end

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               grant_valid_q;
    logic [IW-1:0]      grant_id_q;
    logic               timeout_q;
    logic [IW-1:0]      ptr_q;

    logic               busy;
    logic [IW-1:0]      next_ptr_d;
    logic [NUM_REQ-1:0] pick_req;
    logic [IW-1:0]      pick_ptr;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic               force_rel;
    logic               release_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt_q;
`endif

    // One picker serves both cases: from ptr while idle, and from the
    // post-release pointer with the releasing owner masked while busy.
    always_comb begin
        busy       = (state_q == BUSY);
        next_ptr_d = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        pick_req   = busy ? (req & ~grant_q) : req;
        pick_ptr   = busy ? next_ptr_d : ptr_q;
        force_rel  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // Fire on the edge where the count would reach MAX_HOLD so the owner
        // sees exactly MAX_HOLD cycles of grant before losing it.
        force_rel  = busy && (cnt_q >= CW'(MAX_HOLD - 1)) && (|(req & ~grant_q));
`endif
        release_d  = busy && (done || !req[grant_id_q] || force_rel);
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (pick_found) begin
                        state_q       <= BUSY;
                        grant_q       <= ONE << pick_idx;
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= pick_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_q         <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (release_d) begin
                        ptr_q     <= next_ptr_d;
                        timeout_q <= force_rel;
                        if (pick_found) begin
                            grant_q    <= ONE << pick_idx;
                            grant_id_q <= pick_idx;
`ifdef ARB_TIMEOUT_EN
                            cnt_q      <= '0;
`endif
                        end else begin
                            state_q       <= IDLE;
                            grant_q       <= '0;
                            grant_valid_q <= 1'b0;
                            grant_id_q    <= '0;
                        end
                    end else begin
                        timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        if (cnt_q != CW'(MAX_HOLD)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout     = timeout_q;

endmodule : rr_hold_arbiter

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - directed scoreboard bench for rr_hold_arbiter
module tb_rr_hold_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic       done  = 1'b0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // expected {grant, grant_id, grant_valid, timeout}
    logic [7:0] exp_q [$];

    rr_hold_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] outs();
        return {grant, grant_id, grant_valid, timeout};
    endfunction

    // Drive one cycle of stimulus, record the expected registered result,
    // then compare it after the edge.
    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                        input logic [1:0] eid, input logic eto, input string tag);
        logic [7:0] e;
        @(negedge clock);
        req  = r;
        done = d;
        exp_q.push_back({eg, eid, |eg, eto});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard required one entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, outs(), e);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        cmp("reset_state", outs(), 8'b0000_00_0_0);
        @(negedge clock);
        reset = 1'b0;

        // first grant: nothing before the edge, grant right after it
        @(negedge clock);
        req = 4'b0001;
        exp_q.push_back({4'b0001, 2'd0, 1'b1, 1'b0});
        #1;
        cmp("pre_edge_zero", outs(), 8'b0000_00_0_0);
        @(posedge clock);
        #1;
        cmp("first_grant", outs(), exp_q.pop_front());

        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "drop_to_idle");
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "done_ignored_idle");

        // zero-bubble handoff on done
        step(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, "pick_1010");
        step(4'b1010, 1'b1, 4'b1000, 2'd3, 1'b0, "handoff_no_bubble");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "idle_again");

        // fairness rotation with all requesting
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rot0");
        step(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, "rot1");
        step(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0, "rot2");
        step(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0, "rot3");
        step(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, "rot4_wrap");

        // done together with request drop is a single release
        step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, "done_and_drop_once");

        // owner drops its request, done low
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "drop_handoff");
        cmp("ptr_after_drop", {6'b0, dut.ptr_q}, 8'd3);

        // long hold while another requester waits
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "hold_before_timeout");
        end
        step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, "timeout_release");
        step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "timeout_one_cycle");
`else
        for (int i = 0; i < MAX_HOLD + 4; i++) begin
            step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "no_preempt_hold");
        end
`endif

        // lone owner keeps the grant indefinitely
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "lone_owner");
        for (int i = 0; i < MAX_HOLD + 4; i++) begin
            step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "lone_hold");
        end

        // asynchronous reset between edges
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset", outs(), 8'b0000_00_0_0);
        req  = 4'b1000;
        done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "after_reset_3");

        cmp("scoreboard_drained", {7'b0, exp_q.size() != 0}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rr_hold_arbiter

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle resource between NUM_REQ requesters.
- A winner keeps the grant until it signals done or drops its request. Then ownership passes to the next requester in rotating order with no idle bubble.
- Sits in front of the shared resource; requesters drive req, the current owner drives done.

Parameters:
- NUM_REQ, 4, number of requesters (must be >= 2)
- MAX_HOLD, 8, maximum cycles an owner may hold the grant while others wait (used only with the optional feature)

Ports:
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request, level-sensitive
- done  input  1  owner finished; sampled only while a grant is active
- grant  output  NUM_REQ  one-hot grant, registered
- grant_valid  output  1  OR of grant, registered
- grant_id  output  $clog2(NUM_REQ)  index of the current owner; 0 when idle
- timeout  output  1  one-cycle pulse when an owner is force-released

Behaviour:
- Interface: one clock, named clock; reset is asynchronous and active-high, named reset.
- Reset values:
  - state IDLE; grant, grant_valid, grant_id, timeout all 0.
  - Priority pointer ptr=0; hold counter=0.
  - Reset mid-BUSY drops grant immediately, without waiting for a clock edge.
- States: IDLE, BUSY.
- Pick function: the first set bit of req, searching from index ptr upward and wrapping modulo NUM_REQ.
- IDLE:
  - If req != 0, register grant=onehot(pick), enter BUSY, counter=0.
  - Latency is 1 cycle: req sampled at edge N gives grant visible after edge N.
  - done is ignored in IDLE.
- BUSY:
  - Release condition: done=1, or req[grant_id]=0.
  - No release: hold grant; counter increments, saturating at MAX_HOLD.
  - On release:
    - ptr <= grant_id+1 mod NUM_REQ.
    - Same edge, re-pick from the new ptr using the current req with the releasing owner's bit masked.
    - If the masked set is nonzero, grant the winner and stay BUSY with counter=0 (zero-bubble handoff).
    - If the masked set is empty, go to IDLE with grant=0. The releasing owner can win again in the following IDLE cycle.
- Simultaneous events:
  - New requests arriving during BUSY wait; there is no preemption.
  - done together with the owner's req dropping counts as one release.
- Invariants: grant is always one-hot or zero; grant_valid==|grant; grant_id matches grant.
- Fairness: with all requesters active and releasing, each is served once per NUM_REQ grants.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - When counter reaches MAX_HOLD and some other requester is pending, force a release exactly as for done.
  - Assert timeout for that one cycle, registered with the new grant.
  - If no other requester is pending, the owner keeps the grant and the counter saturates.
- Undefined: no forced release; the counter may be omitted; timeout is tied to 0.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - default constants ARB_NUM_REQ=4 and ARB_MAX_HOLD=8.
- Sub-module rr_pick: combinational rotate-priority pick (inputs req, ptr; outputs found and index), instantiated once.

Test Plan:
- Reset, then req=0001 -> after the next posedge grant=0001, grant_valid=1, grant_id=0; before that edge grant=0000.
- From IDLE with ptr=0, req=1010 -> grant=0010. Pulse done -> next cycle grant=1000 with no zero-grant cycle between.
- req=1111 held, done pulsed once per grant -> grant sequence 0001, 0010, 0100, 1000, 0001.
- Owner (grant=0100) drops req3:2 to 00 with req=0001 still high and done=0 -> next cycle grant=0001 and ptr=3.
- ARB_TIMEOUT_EN defined, MAX_HOLD=8, req=0011, done=0 -> grant=0001 for 8 cycles, then grant=0010 with timeout=1 for exactly one cycle. Repeat with req=0001 only -> no timeout, grant stays 0001.
- Assert reset asynchronously mid-BUSY between edges -> grant=0000 immediately. After reset release with req=1000 -> grant=1000, grant_id=3.
